// File: rtl/trigger_conditioner.sv
// Trigger conditioner: synchronises the raw trigger pin, rejects short pulses and emits an
// armed, holdoff-limited trigger level plus a one-cycle strobe and a saturating trigger count.
module trigger_conditioner #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_COUNT  = 32'd30,
    parameter int unsigned HOLDOFF_COUNT = 32'd3_000_000,
    parameter bit          ACTIVE_HIGH   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        trig_in,
    input  logic        arm,
    output logic        trig_out,
    output logic        trig_pulse,
    output logic        armed,
    output logic [15:0] trig_count
);

    localparam logic INACTIVE_RAW = ~ACTIVE_HIGH;

    typedef enum logic [2:0] {
        StIdle,
        StWaitInactive,
        StArmed,
        StFired,
        StHoldoff
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_act;
    logic                   filt_q, filt_d, filt_eff;
    logic [31:0]            filt_cnt_q, filt_cnt_d;
    logic [31:0]            hold_cnt_q, hold_cnt_d;
    state_e                 state_q, state_d;
    logic                   trig_out_q, trig_out_d;
    logic                   trig_pulse_q, trig_pulse_d;
    logic [15:0]            trig_count_q, trig_count_d;

    // Polarity correction: sync_act is 1 whenever the pin is at its active level.
    assign sync_act = sync_q[SYNC_STAGES-1] ~^ ACTIVE_HIGH;

    // With the filter bypassed the synchronised level feeds the FSM directly.
    assign filt_eff = (FILTER_COUNT == 0) ? sync_act : filt_q;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (FILTER_COUNT == 0) begin
            filt_d = sync_act;
        end else if (sync_act != filt_q) begin
            if (filt_cnt_q + 32'd1 >= FILTER_COUNT) begin
                filt_d = sync_act;
            end else begin
                filt_cnt_d = filt_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        trig_out_d   = trig_out_q;
        trig_pulse_d = 1'b0;
        trig_count_d = trig_count_q;
        if (!arm) begin
            // Disarm wins over a qualified edge in the same cycle.
            state_d    = StIdle;
            trig_out_d = 1'b0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StWaitInactive;
                end
                StWaitInactive: begin
                    if (!filt_eff) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (filt_eff) begin
                        state_d      = StFired;
                        trig_out_d   = 1'b1;
                        trig_pulse_d = 1'b1;
                        if (trig_count_q != 16'hFFFF) begin
                            trig_count_d = trig_count_q + 16'd1;
                        end
                    end
                end
                StFired: begin
                    if (!filt_eff) begin
                        trig_out_d = 1'b0;
                        hold_cnt_d = '0;
                        state_d    = (HOLDOFF_COUNT == 0) ? StArmed : StHoldoff;
                    end
                end
                StHoldoff: begin
                    if (hold_cnt_q + 32'd1 >= HOLDOFF_COUNT) begin
                        state_d    = StWaitInactive;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    trig_out_d = 1'b0;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q       <= {SYNC_STAGES{INACTIVE_RAW}};
            filt_q       <= 1'b0;
            filt_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            state_q      <= StIdle;
            trig_out_q   <= 1'b0;
            trig_pulse_q <= 1'b0;
            trig_count_q <= '0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], trig_in};
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            state_q      <= state_d;
            trig_out_q   <= trig_out_d;
            trig_pulse_q <= trig_pulse_d;
            trig_count_q <= trig_count_d;
        end
    end

    assign trig_out   = trig_out_q;
    assign trig_pulse = trig_pulse_q;
    assign trig_count = trig_count_q;
    assign armed      = (state_q == StWaitInactive) || (state_q == StArmed);

endmodule

// File: tb/tb_trigger_conditioner.sv
// Bench for trigger_conditioner: directed scenarios with literal expectations plus randomized
// stimulus, all outputs compared every cycle against a behavioural reference model.
module tb_trigger_conditioner;

    localparam int unsigned SYNC     = 2;
    localparam int unsigned FILT     = 4;
    localparam int unsigned HOLD     = 10;
    localparam bit          ACT_HIGH = 1'b1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        trig_in;
    logic        arm;
    logic        trig_out;
    logic        trig_pulse;
    logic        armed;
    logic [15:0] trig_count;

    int n_vec = 0;
    int n_err = 0;

    trigger_conditioner #(
        .SYNC_STAGES  (SYNC),
        .FILTER_COUNT (FILT),
        .HOLDOFF_COUNT(HOLD),
        .ACTIVE_HIGH  (ACT_HIGH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .trig_in   (trig_in),
        .arm       (arm),
        .trig_out  (trig_out),
        .trig_pulse(trig_pulse),
        .armed     (armed),
        .trig_count(trig_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw-sample history, run-length filter and a few mode flags.
    bit raw_hist[$];
    bit m_valid = 1'b0;
    bit m_filt, m_active, m_wait_low, m_fired, m_out, m_pulse;
    int m_run, m_hold_left, m_count;

    always @(posedge clk) begin : ref_model
        bit s_old, f_old;
        if (!resetn) begin
            raw_hist.delete();
            for (int i = 0; i < int'(SYNC); i++) raw_hist.push_back(!ACT_HIGH);
            m_filt = 0; m_run = 0; m_active = 0; m_wait_low = 0; m_fired = 0;
            m_hold_left = 0; m_out = 0; m_pulse = 0; m_count = 0; m_valid = 1;
        end else begin
            s_old = (raw_hist[SYNC-1] == ACT_HIGH);
            f_old = m_filt;
            if (s_old != m_filt) begin
                m_run++;
                if (m_run >= int'(FILT)) begin
                    m_filt = s_old;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_pulse = 0;
            if (!arm) begin
                m_active = 0; m_wait_low = 0; m_fired = 0; m_hold_left = 0; m_out = 0;
            end else if (!m_active) begin
                m_active = 1; m_wait_low = 1;
            end else if (m_wait_low) begin
                if (!f_old) m_wait_low = 0;
            end else if (m_hold_left > 0) begin
                m_hold_left--;
                if (m_hold_left == 0) m_wait_low = 1;
            end else if (m_fired) begin
                if (!f_old) begin
                    m_fired = 0; m_out = 0; m_hold_left = int'(HOLD);
                end
            end else if (f_old) begin
                m_fired = 1; m_out = 1; m_pulse = 1;
                if (m_count < 65535) m_count++;
            end
            raw_hist.push_front(trig_in);
            void'(raw_hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_trig_out", {31'd0, trig_out}, {31'd0, m_out});
            check("model_trig_pulse", {31'd0, trig_pulse}, {31'd0, m_pulse});
            check("model_armed", {31'd0, armed},
                  {31'd0, m_active && !m_fired && (m_hold_left == 0)});
            check("model_trig_count", {16'd0, trig_count}, m_count);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts rising clock edges (first = next edge) until trig_out reaches lvl; -1 on timeout.
    task automatic wait_out(input logic lvl, output int edges);
        edges = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (trig_out === lvl) begin
                edges = e;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int          e;
        int unsigned r;
        resetn  = 1'b0;
        arm     = 1'b0;
        trig_in = 1'b0;
        cycles(3);
        resetn = 1'b1;
        #1;
        check("rst_trig_out", {31'd0, trig_out}, 0);
        check("rst_trig_pulse", {31'd0, trig_pulse}, 0);
        check("rst_armed", {31'd0, armed}, 0);
        check("rst_trig_count", {16'd0, trig_count}, 0);

        // Clean trigger: rise latency, one-cycle strobe, fall latency.
        @(negedge clk); arm = 1'b1;
        cycles(3);
        trig_in = 1'b1;
        wait_out(1'b1, e);
        check("rise_latency", e, 7);
        check("pulse_high", {31'd0, trig_pulse}, 1);
        @(posedge clk); #1;
        check("pulse_one_cycle", {31'd0, trig_pulse}, 0);
        check("count_first", {16'd0, trig_count}, 1);
        cycles(13);
        trig_in = 1'b0;
        wait_out(1'b0, e);
        check("fall_latency", e, 7);

        // Rise well after holdoff ends is accepted.
        repeat (14) @(negedge clk);
        trig_in = 1'b1;
        wait_out(1'b1, e);
        check("post_holdoff_latency", e, 7);
        check("count_second", {16'd0, trig_count}, 2);
        cycles(13);
        trig_in = 1'b0;
        wait_out(1'b0, e);

        // Rise during holdoff is ignored even when held.
        repeat (4) @(negedge clk);
        trig_in = 1'b1;
        cycles(20);
        check("holdoff_ignored_out", {31'd0, trig_out}, 0);
        check("holdoff_ignored_count", {16'd0, trig_count}, 2);
        trig_in = 1'b0;
        cycles(15);

        // Short pulses never pass the filter.
        for (int i = 0; i < 5; i++) begin
            trig_in = 1'b1;
            cycles(3);
            trig_in = 1'b0;
            cycles(3);
        end
        check("short_pulse_out", {31'd0, trig_out}, 0);
        check("short_pulse_count", {16'd0, trig_count}, 2);

        // Level already active at arm time never fires; a fresh rise does.
        arm     = 1'b0;
        trig_in = 1'b1;
        cycles(10);
        arm = 1'b1;
        cycles(20);
        check("pre_armed_level_out", {31'd0, trig_out}, 0);
        check("pre_armed_level_count", {16'd0, trig_count}, 2);
        check("pre_armed_waiting", {31'd0, armed}, 1);
        trig_in = 1'b0;
        cycles(10);
        trig_in = 1'b1;
        wait_out(1'b1, e);
        check("rearm_latency", e, 7);
        check("count_third", {16'd0, trig_count}, 3);

        // Disarm while fired.
        @(negedge clk); arm = 1'b0;
        @(posedge clk); #1;
        check("disarm_out", {31'd0, trig_out}, 0);
        check("disarm_armed", {31'd0, armed}, 0);
        @(negedge clk); trig_in = 1'b0;
        cycles(10);

        // Reset while fired, then saturation.
        arm = 1'b1;
        cycles(3);
        trig_in = 1'b1;
        wait_out(1'b1, e);
        @(negedge clk);
        resetn  = 1'b0;
        trig_in = 1'b0;
        @(posedge clk); #1;
        check("midrst_trig_out", {31'd0, trig_out}, 0);
        check("midrst_trig_pulse", {31'd0, trig_pulse}, 0);
        check("midrst_armed", {31'd0, armed}, 0);
        check("midrst_trig_count", {16'd0, trig_count}, 0);
        @(negedge clk); resetn = 1'b1;
        cycles(4);
        #2;
        force dut.trig_count_q = 16'hFFFF;
        m_count = 65535;
        #1;
        release dut.trig_count_q;
        @(negedge clk); trig_in = 1'b1;
        wait_out(1'b1, e);
        check("sat_latency", e, 7);
        check("sat_count", {16'd0, trig_count}, 32'h0000_FFFF);
        @(negedge clk); trig_in = 1'b0;
        cycles(20);

        // Randomized pulses, disarms and resets against the model.
        arm = 1'b1;
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            @(negedge clk);
            if (r < 6) arm = ~arm;
            else if (r < 8) resetn = 1'b0;
            trig_in = 1'b1;
            repeat ($urandom_range(1, 25)) @(negedge clk);
            resetn  = 1'b1;
            trig_in = 1'b0;
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
